// File: rtl/reg_scoreboard_if.sv
// Issue and writeback bundle for the register scoreboard.
// The master side is decode/writeback; the slave side is the scoreboard.
interface reg_scoreboard_if;
  logic       issue_valid;
  logic       issue_we;
  logic [4:0] issue_dst;
  logic       issue_use_a;
  logic [4:0] issue_src_a;
  logic       issue_use_b;
  logic [4:0] issue_src_b;
  logic       issue_stall;
  logic       wb_we;
  logic [4:0] wb_addr;
  logic [5:0] busy_count;
  logic       wb_err;

  modport master (
    output issue_valid, issue_we, issue_dst, issue_use_a, issue_src_a,
           issue_use_b, issue_src_b, wb_we, wb_addr,
    input  issue_stall, busy_count, wb_err
  );

  modport slave (
    input  issue_valid, issue_we, issue_dst, issue_use_a, issue_src_a,
           issue_use_b, issue_src_b, wb_we, wb_addr,
    output issue_stall, busy_count, wb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters that stall decode on RAW hazards and
// counter saturation; a same-cycle writeback releases its reader immediately.
module reg_scoreboard #(
  parameter int CNT_W = 2,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  reg_scoreboard_if.slave sb
);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [NREGS-1:0][CNT_W-1:0] pend_q, pend_d, eff;
  logic [NREGS-1:0]            wbhit, inc;
  logic [5:0]                  busy_q, busy_d;
  logic                        err_q, err_d;
  logic                        haz_a, haz_b, haz_d, stall, accept;

  // Writeback credit: the register file writes on negedge, so a value landing
  // this cycle is already readable and no longer counts as pending.
  always_comb begin
    wbhit = '0;
    eff   = '0;
    for (int r = 1; r < NREGS; r++) begin
      wbhit[r] = sb.wb_we && (sb.wb_addr == 5'(r)) && (pend_q[r] != '0);
      eff[r]   = pend_q[r] - CNT_W'(wbhit[r]);
    end
  end

  always_comb begin
    haz_a  = sb.issue_use_a && (sb.issue_src_a != 5'd0) && (eff[sb.issue_src_a] != '0);
    haz_b  = sb.issue_use_b && (sb.issue_src_b != 5'd0) && (eff[sb.issue_src_b] != '0);
    haz_d  = sb.issue_we    && (sb.issue_dst   != 5'd0) && (eff[sb.issue_dst]   == MAX);
    stall  = sb.issue_valid && !reset && (haz_a || haz_b || haz_d);
    accept = sb.issue_valid && !stall && sb.issue_we && (sb.issue_dst != 5'd0);
  end

  // Issue and writeback on the same register cancel; saturation is blocked by
  // haz_d so the counter never wraps.
  always_comb begin
    pend_d = pend_q;
    inc    = '0;
    busy_d = '0;
    for (int r = 1; r < NREGS; r++) begin
      inc[r]    = accept && (sb.issue_dst == 5'(r));
      pend_d[r] = pend_q[r] + CNT_W'(inc[r]) - CNT_W'(wbhit[r]);
      busy_d    = busy_d + 6'(pend_d[r] != '0);
    end
    pend_d[0] = '0;
    err_d = err_q || (sb.wb_we && (sb.wb_addr != 5'd0) && (pend_q[sb.wb_addr] == '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign sb.issue_stall = stall;
  assign sb.busy_count  = busy_q;
  assign sb.wb_err      = err_q;
endmodule
